// File: rtl/multiply_divide_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO pair (MULT[U], DIV[U], MTHI, MTLO).
// Optional build macro MDU_FAST_MULTIPLY_EN: single-cycle combinational multiply; divide stays iterative.

package multiply_divide_unit_pkg;
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_operator_t;
endpackage

module multiply_divide_unit
  import multiply_divide_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  mdu_operator_t         operator,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic                  flush,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int unsigned W      = DATA_WIDTH;
  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned CNT_W  = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MULTIPLY = 2'd1,
    DIVIDE   = 2'd2
  } state_t;

  state_t state, next_state;

  // work holds {partial product | multiplier} or {remainder | dividend/quotient}
  logic [PROD_W-1:0] work;
  logic [W-1:0]      divisor_q;
  logic [W-1:0]      dividend_q;
  logic [CNT_W-1:0]  count;
  logic              neg_q;
  logic              rem_neg_q;
  logic              dbz_q;

  logic              accept_c;
  logic              op_signed_c;
  logic              op1_neg_c;
  logic              op2_neg_c;
  logic [W-1:0]      op1_mag_c;
  logic [W-1:0]      op2_mag_c;
  logic [W:0]        mul_sum_c;
  logic [PROD_W-1:0] mul_next_c;
  logic [PROD_W-1:0] mul_result_c;
  logic [W:0]        div_shift_c;
  logic              div_ok_c;
  logic [W-1:0]      div_diff_c;
  logic [PROD_W-1:0] div_next_c;
  logic [W-1:0]      div_quo_c;
  logic [W-1:0]      div_rem_c;
`ifdef MDU_FAST_MULTIPLY_EN
  logic [PROD_W-1:0] fast_prod_c;
`endif

  // Operand preparation and one iteration of each datapath
  always_comb begin
    accept_c     = start && !flush && (state == IDLE);
    op_signed_c  = (operator == MDU_MULT) || (operator == MDU_DIV);
    op1_neg_c    = op_signed_c && operand1[W-1];
    op2_neg_c    = op_signed_c && operand2[W-1];
    op1_mag_c    = op1_neg_c ? -operand1 : operand1;
    op2_mag_c    = op2_neg_c ? -operand2 : operand2;

    mul_sum_c    = {1'b0, work[PROD_W-1:W]} + (work[0] ? {1'b0, divisor_q} : '0);
    mul_next_c   = {mul_sum_c, work[W-1:1]};
    mul_result_c = neg_q ? -mul_next_c : mul_next_c;

    // Restoring step: the shifted remainder can exceed W bits only when it beats the divisor
    div_shift_c  = work[PROD_W-1:W-1];
    div_ok_c     = div_shift_c[W] || (div_shift_c[W-1:0] >= divisor_q);
    div_diff_c   = div_shift_c[W-1:0] - divisor_q;
    div_next_c   = div_ok_c ? {div_diff_c, work[W-2:0], 1'b1}
                            : {div_shift_c[W-1:0], work[W-2:0], 1'b0};
    div_quo_c    = dbz_q ? '1 : (neg_q ? -div_next_c[W-1:0] : div_next_c[W-1:0]);
    div_rem_c    = dbz_q ? dividend_q
                         : (rem_neg_q ? -div_next_c[PROD_W-1:W] : div_next_c[PROD_W-1:W]);
`ifdef MDU_FAST_MULTIPLY_EN
    fast_prod_c  = PROD_W'(op1_mag_c) * PROD_W'(op2_mag_c);
    if (op1_neg_c ^ op2_neg_c) fast_prod_c = -fast_prod_c;
`endif
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept_c) begin
          case (operator)
`ifndef MDU_FAST_MULTIPLY_EN
            MDU_MULT, MDU_MULTU: next_state = MULTIPLY;
`endif
            MDU_DIV, MDU_DIVU:   next_state = DIVIDE;
            default:             next_state = IDLE;
          endcase
        end
      end
      MULTIPLY, DIVIDE: begin
        if (flush || (count == CNT_LAST)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State, datapath and HI/LO registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      work       <= '0;
      divisor_q  <= '0;
      dividend_q <= '0;
      count      <= '0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (accept_c) begin
            case (operator)
              MDU_MTHI: hi <= operand1;
              MDU_MTLO: lo <= operand1;
              MDU_MULT, MDU_MULTU: begin
`ifdef MDU_FAST_MULTIPLY_EN
                {hi, lo} <= fast_prod_c;
`else
                work      <= {W'(0), op1_mag_c};
                divisor_q <= op2_mag_c;
                neg_q     <= op1_neg_c ^ op2_neg_c;
                count     <= '0;
`endif
              end
              MDU_DIV, MDU_DIVU: begin
                work       <= {W'(0), op1_mag_c};
                divisor_q  <= op2_mag_c;
                dividend_q <= operand1;
                neg_q      <= op1_neg_c ^ op2_neg_c;
                rem_neg_q  <= op1_neg_c;
                dbz_q      <= (operand2 == '0);
                count      <= '0;
              end
              default: ;
            endcase
          end
        end
        MULTIPLY: begin
          if (!flush) begin
            work  <= mul_next_c;
            count <= count + CNT_W'(1);
            if (count == CNT_LAST) {hi, lo} <= mul_result_c;
          end
        end
        DIVIDE: begin
          if (!flush) begin
            work  <= div_next_c;
            count <= count + CNT_W'(1);
            if (count == CNT_LAST) begin
              lo <= div_quo_c;
              hi <= div_rem_c;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
